// File: rtl/alu_pkg.sv
// Shared definitions for the ALU share arbiter.
//   ALU_DATA_W/ALU_CTL_W/ALU_TAG_W : default operand, ALU_Ctl and tag widths
//   ALU_* codes                    : ALU_Ctl encodings understood by the ALU
//   arb_state_e                    : arbiter FSM state encoding
//   ctl_is_legal()                 : true for the six implemented ALU_Ctl codes
package alu_pkg;
    localparam int ALU_DATA_W = 32;
    localparam int ALU_CTL_W  = 4;
    localparam int ALU_TAG_W  = 4;

    localparam logic [ALU_CTL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTL_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_e;

    function automatic logic ctl_is_legal(input logic [ALU_CTL_W-1:0] ctl);
        case (ctl)
            ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ctl_is_legal = 1'b1;
            default:                                             ctl_is_legal = 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
//   master : requester side (drives ReqN_*, RspN_Ready)
//   slave  : arbiter side (drives ReqN_Ready, RspN_Valid, Rsp_*, Busy)
// Rsp_Data/Rsp_Zero/Rsp_Tag/Rsp_Err are shared and qualified by RspN_Valid.
interface alu_share_arbiter_if #(
    parameter int DATA_W = alu_pkg::ALU_DATA_W,
    parameter int CTL_W  = alu_pkg::ALU_CTL_W,
    parameter int TAG_W  = alu_pkg::ALU_TAG_W
);
    logic              Req0_Valid, Req0_Ready, Req1_Valid, Req1_Ready;
    logic [DATA_W-1:0] Req0_A, Req0_B, Req1_A, Req1_B;
    logic [CTL_W-1:0]  Req0_Ctl, Req1_Ctl;
    logic [TAG_W-1:0]  Req0_Tag, Req1_Tag;
    logic              Rsp0_Valid, Rsp0_Ready, Rsp1_Valid, Rsp1_Ready;
    logic [DATA_W-1:0] Rsp_Data;
    logic              Rsp_Zero, Rsp_Err, Busy;
    logic [TAG_W-1:0]  Rsp_Tag;

    modport master (
        output Req0_Valid, Req0_A, Req0_B, Req0_Ctl, Req0_Tag,
        output Req1_Valid, Req1_A, Req1_B, Req1_Ctl, Req1_Tag,
        output Rsp0_Ready, Rsp1_Ready,
        input  Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid,
        input  Rsp_Data, Rsp_Zero, Rsp_Tag, Rsp_Err, Busy
    );

    modport slave (
        input  Req0_Valid, Req0_A, Req0_B, Req0_Ctl, Req0_Tag,
        input  Req1_Valid, Req1_A, Req1_B, Req1_Ctl, Req1_Tag,
        input  Rsp0_Ready, Rsp1_Ready,
        output Req0_Ready, Req1_Ready, Rsp0_Valid, Rsp1_Valid,
        output Rsp_Data, Rsp_Zero, Rsp_Tag, Rsp_Err, Busy
    );
endinterface

// File: rtl/ALU.sv
// The 32-bit MIPS ALU shared by the arbiter. Purely combinational.
//   A, B      in  operands
//   ALU_Ctl   in  operation code (see alu_pkg)
//   Output    out result; unimplemented codes produce 0
//   Zero_Flag out Output == 0
module ALU
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W
) (
    input  logic [DATA_W-1:0]    A,
    input  logic [DATA_W-1:0]    B,
    input  logic [ALU_CTL_W-1:0] ALU_Ctl,
    output logic [DATA_W-1:0]    Output,
    output logic                 Zero_Flag
);
    always_comb begin
        Output = '0;
        case (ALU_Ctl)
            ALU_AND: Output = A & B;
            ALU_OR:  Output = A | B;
            ALU_ADD: Output = A + B;
            ALU_SUB: Output = A - B;
            ALU_SLT: Output = {{(DATA_W-1){1'b0}}, ($signed(A) < $signed(B))};
            ALU_NOR: Output = ~(A | B);
            default: Output = '0;
        endcase
    end

    assign Zero_Flag = (Output == '0);
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one ALU between the execute path (req 0) and
// the branch/address unit (req 1). One operation in flight:
// IDLE (accept) -> EXEC (ALU result registered) -> RESP (hold until taken).
//   Clk      in  clock, rising edge
//   Reset_n  in  asynchronous active-low reset
//   bus      slave side of alu_share_arbiter_if (requests, responses, Busy)
// Optional feature macro: ALU_ARB_ILLEGAL_OP_EN -- when defined, a Ctl code
// outside the six implemented ones returns Data=0, Zero=0, Err=1.
// Parameters must match those of the connected interface instance.
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int CTL_W  = ALU_CTL_W,
    parameter int TAG_W  = ALU_TAG_W
) (
    input  logic          Clk,
    input  logic          Reset_n,
    alu_share_arbiter_if.slave bus
);
    arb_state_e        state_q;
    logic              ptr_q, gnt_q, busy_q, rsp_zero_q;
    logic [1:0]        rsp_vld_q;
    logic [DATA_W-1:0] a_q, b_q, rsp_data_q;
    logic [CTL_W-1:0]  ctl_q;
    logic [TAG_W-1:0]  tag_q;

    logic              any_vld, sel_d, accept, rsp_take, alu_zero;
    logic [DATA_W-1:0] a_d, b_d, alu_out;
    logic [CTL_W-1:0]  ctl_d;
    logic [TAG_W-1:0]  tag_d;

    // Contention goes to the pointer; a lone request always wins.
    assign any_vld = bus.Req0_Valid | bus.Req1_Valid;
    assign sel_d   = (bus.Req0_Valid & bus.Req1_Valid) ? ptr_q : bus.Req1_Valid;
    // Reset_n gating keeps Ready low while reset is held.
    assign accept  = Reset_n & (state_q == ST_IDLE) & any_vld;

    assign bus.Req0_Ready = accept & ~sel_d;
    assign bus.Req1_Ready = accept &  sel_d;

    assign a_d   = sel_d ? bus.Req1_A   : bus.Req0_A;
    assign b_d   = sel_d ? bus.Req1_B   : bus.Req0_B;
    assign ctl_d = sel_d ? bus.Req1_Ctl : bus.Req0_Ctl;
    assign tag_d = sel_d ? bus.Req1_Tag : bus.Req0_Tag;

    assign rsp_take = gnt_q ? bus.Rsp1_Ready : bus.Rsp0_Ready;

    ALU #(.DATA_W(DATA_W)) u_alu (
        .A         (a_q),
        .B         (b_q),
        .ALU_Ctl   (ctl_q),
        .Output    (alu_out),
        .Zero_Flag (alu_zero)
    );

`ifdef ALU_ARB_ILLEGAL_OP_EN
    logic err_q, illegal;
    assign illegal     = ~ctl_is_legal(ctl_q);
    assign bus.Rsp_Err = err_q;
`else
    assign bus.Rsp_Err = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 1'b0;
            gnt_q      <= 1'b0;
            busy_q     <= 1'b0;
            rsp_vld_q  <= '0;
            rsp_data_q <= '0;
            rsp_zero_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            ctl_q      <= '0;
            tag_q      <= '0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
            err_q      <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: if (any_vld) begin
                    a_q     <= a_d;
                    b_q     <= b_d;
                    ctl_q   <= ctl_d;
                    tag_q   <= tag_d;
                    gnt_q   <= sel_d;
                    busy_q  <= 1'b1;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
`ifdef ALU_ARB_ILLEGAL_OP_EN
                    rsp_data_q <= illegal ? '0 : alu_out;
                    rsp_zero_q <= illegal ? 1'b0 : alu_zero;
                    err_q      <= illegal;
`else
                    rsp_data_q <= alu_out;
                    rsp_zero_q <= alu_zero;
`endif
                    rsp_vld_q  <= gnt_q ? 2'b10 : 2'b01;
                    state_q    <= ST_RESP;
                end
                ST_RESP: if (rsp_take) begin
                    rsp_vld_q <= '0;
                    busy_q    <= 1'b0;
                    ptr_q     <= ~gnt_q;   // the other requester wins the next tie
                    state_q   <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.Rsp0_Valid = rsp_vld_q[0];
    assign bus.Rsp1_Valid = rsp_vld_q[1];
    assign bus.Rsp_Data   = rsp_data_q;
    assign bus.Rsp_Zero   = rsp_zero_q;
    assign bus.Rsp_Tag    = tag_q;
    assign bus.Busy       = busy_q;
endmodule
